// File: rtl/button_reset_conditioner_pkg.sv
// Shared definitions for the button/reset conditioner: reset FSM encoding and
// debounce defaults for simulation and the board.
package button_reset_conditioner_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } rst_state_e;

  localparam int DEBOUNCE_CYCLES_SIM   = 4;
  localparam int DEBOUNCE_CYCLES_BOARD = 500000;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/button_reset_conditioner_if.sv
// Board-side button bundle: raw pins in, conditioned levels/edges and the
// stretched core reset out.
interface button_reset_conditioner_if #(
  parameter int NUM_BTN = 3
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic               sys_reset_n;
  logic               reset_busy;

  modport master (
    output btn_raw,
    input  btn_level, btn_press, btn_release, sys_reset_n, reset_busy
  );

  modport slave (
    input  btn_raw,
    output btn_level, btn_press, btn_release, sys_reset_n, reset_busy
  );

endinterface

// File: rtl/button_reset_conditioner_btn_debounce.sv
// One button channel: 2-flop synchroniser, stability counter and registered
// press/release pulses. Raw pin is active-low, level output is active-high.
module btn_debounce
  import button_reset_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic btn_level_o,
  output logic btn_press_o,
  output logic btn_release_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, release_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    accept  = 1'b0;
    // Any sample agreeing with the accepted level restarts the count.
    if (~sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        accept  = 1'b1;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= btn_raw_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= accept & ~level_q;
      release_q <= accept & level_q;
    end
  end

  assign btn_level_o   = level_q;
  assign btn_press_o   = press_q;
  assign btn_release_o = release_q;

endmodule

// File: rtl/button_reset_conditioner.sv
// Debounces the board buttons and drives a stretched, retriggerable reset to
// the MIPS core from the debounced press of the reset button.
module button_reset_conditioner
  import button_reset_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int RESET_HOLD      = 8,
  parameter int RST_BTN         = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  button_reset_conditioner_if.slave bus
);

  localparam int            HW        = cnt_width(RESET_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

  logic [NUM_BTN-1:0] level_w, press_w, release_w;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .btn_raw_i    (bus.btn_raw[i]),
      .btn_level_o  (level_w[i]),
      .btn_press_o  (press_w[i]),
      .btn_release_o(release_w[i])
    );
  end

  rst_state_e    state_q;
  logic [HW-1:0] hold_cnt_q;
  logic          sys_reset_n_q, busy_q;
  logic          rst_press;

  assign rst_press = press_w[RST_BTN];

  // A press edge always wins, even on the last HOLD cycle, so a retrigger
  // yields a full fresh hold period.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_HOLD;
      hold_cnt_q    <= '0;
      sys_reset_n_q <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (rst_press) begin
            hold_cnt_q <= '0;
          end else if (hold_cnt_q == HOLD_LAST) begin
            state_q       <= ST_RUN;
            hold_cnt_q    <= '0;
            sys_reset_n_q <= 1'b1;
            busy_q        <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (rst_press) begin
            state_q       <= ST_HOLD;
            hold_cnt_q    <= '0;
            sys_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        default: begin
          state_q       <= ST_HOLD;
          hold_cnt_q    <= '0;
          sys_reset_n_q <= 1'b0;
          busy_q        <= 1'b1;
        end
      endcase
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_w;
  assign bus.btn_release = release_w;
  assign bus.sys_reset_n = sys_reset_n_q;
  assign bus.reset_busy  = busy_q;

endmodule

// File: tb/tb_button_reset_conditioner.sv
// Directed bench for button_reset_conditioner with default parameters
// (3 buttons, debounce 4, hold 8, reset button 0).
module tb_button_reset_conditioner;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  button_reset_conditioner_if #(.NUM_BTN(3)) bus ();

  button_reset_conditioner #(
    .NUM_BTN        (3),
    .DEBOUNCE_CYCLES(4),
    .RESET_HOLD     (8),
    .RST_BTN        (0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b0;
    bus.btn_raw = 3'b111;
    step();
    step();
    step();
    checks++;
    if (bus.sys_reset_n !== 1'b0 || bus.reset_busy !== 1'b1) begin
      failures++;
      $display("FAIL por_reset_vals got srn=%b busy=%b exp srn=0 busy=1", bus.sys_reset_n, bus.reset_busy);
    end
    checks++;
    if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.btn_release !== 3'b000) begin
      failures++;
      $display("FAIL por_btn_outs got lvl=%b prs=%b rel=%b exp all 0", bus.btn_level, bus.btn_press, bus.btn_release);
    end
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (bus.sys_reset_n !== (k >= 8) || bus.reset_busy !== (k < 8)) begin
        failures++;
        $display("FAIL por_hold k=%0d got srn=%b busy=%b exp srn=%b", k, bus.sys_reset_n, bus.reset_busy, k >= 8);
      end
      checks++;
      if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.btn_release !== 3'b000) begin
        failures++;
        $display("FAIL por_idle_btn k=%0d got lvl=%b prs=%b rel=%b exp 0", k, bus.btn_level, bus.btn_press, bus.btn_release);
      end
    end
  endtask

  task automatic test_clean_press();
    bus.btn_raw[1] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (bus.btn_level[1] !== (k >= 6) || bus.btn_press[1] !== (k == 6) || bus.btn_release[1] !== 1'b0) begin
        failures++;
        $display("FAIL press_b1 k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b rel=0", k,
                 bus.btn_level[1], bus.btn_press[1], bus.btn_release[1], k >= 6, k == 6);
      end
    end
    for (int k = 0; k < 13; k++) step();
    bus.btn_raw[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      checks++;
      if (bus.btn_level[1] !== (k < 6) || bus.btn_release[1] !== (k == 6) || bus.btn_press[1] !== 1'b0) begin
        failures++;
        $display("FAIL release_b1 k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=0 rel=%b", k,
                 bus.btn_level[1], bus.btn_press[1], bus.btn_release[1], k < 6, k == 6);
      end
    end
    checks++;
    if (bus.sys_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL press_b1_no_reset got srn=%b exp 1", bus.sys_reset_n);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pattern;
    pattern = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      bus.btn_raw[2] = pattern[k];
      step();
      checks++;
      if (bus.btn_press[2] !== 1'b0 || bus.btn_level[2] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_quiet k=%0d got prs=%b lvl=%b exp 0", k, bus.btn_press[2], bus.btn_level[2]);
      end
    end
    bus.btn_raw[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (bus.btn_level[2] !== (k == 6) || bus.btn_press[2] !== (k == 6) || bus.btn_release[2] !== 1'b0) begin
        failures++;
        $display("FAIL bounce_settle k=%0d got lvl=%b prs=%b rel=%b exp lvl=%b prs=%b", k,
                 bus.btn_level[2], bus.btn_press[2], bus.btn_release[2], k == 6, k == 6);
      end
    end
    bus.btn_raw[2] = 1'b1;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (bus.btn_level[2] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_released got lvl=%b exp 0", bus.btn_level[2]);
    end
  endtask

  task automatic test_glitch();
    bus.btn_raw[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 3) bus.btn_raw[1] = 1'b1;
      checks++;
      if (bus.btn_level[1] !== 1'b0 || bus.btn_press[1] !== 1'b0 || bus.btn_release[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch_b1 k=%0d got lvl=%b prs=%b rel=%b exp 0", k,
                 bus.btn_level[1], bus.btn_press[1], bus.btn_release[1]);
      end
    end
  endtask

  // First press enters HOLD; a second debounced press lands on the last HOLD
  // cycle and must restart a full hold. The button stays held afterwards.
  task automatic test_reset_button();
    bit exp_low;
    bus.btn_raw[0] = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      step();
      if (k == 4) bus.btn_raw[0] = 1'b1;
      if (k == 8) bus.btn_raw[0] = 1'b0;
      exp_low = (k >= 7) && (k <= 22);
      checks++;
      if (bus.sys_reset_n !== !exp_low || bus.reset_busy !== exp_low) begin
        failures++;
        $display("FAIL rstbtn_hold k=%0d got srn=%b busy=%b exp srn=%b", k, bus.sys_reset_n, bus.reset_busy, !exp_low);
      end
      checks++;
      if (bus.btn_press[0] !== (k == 6 || k == 14) || bus.btn_release[0] !== (k == 10)) begin
        failures++;
        $display("FAIL rstbtn_edges k=%0d got prs=%b rel=%b exp prs=%b rel=%b", k,
                 bus.btn_press[0], bus.btn_release[0], k == 6 || k == 14, k == 10);
      end
    end
    bus.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (bus.sys_reset_n !== 1'b1 || bus.btn_release[0] !== (k == 6)) begin
        failures++;
        $display("FAIL rstbtn_release k=%0d got srn=%b rel=%b exp srn=1 rel=%b", k,
                 bus.sys_reset_n, bus.btn_release[0], k == 6);
      end
    end
  endtask

  task automatic test_midway_reset();
    bus.btn_raw[2] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (bus.btn_level[2] !== 1'b1) begin
      failures++;
      $display("FAIL mid_setup_b2 got lvl=%b exp 1", bus.btn_level[2]);
    end
    bus.btn_raw[1] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.btn_level !== 3'b000 || bus.btn_press !== 3'b000 || bus.sys_reset_n !== 1'b0 || bus.reset_busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_debounce_reset got lvl=%b prs=%b srn=%b busy=%b exp 000 000 0 1",
               bus.btn_level, bus.btn_press, bus.sys_reset_n, bus.reset_busy);
    end
    step();
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (bus.sys_reset_n !== 1'b0 || bus.btn_level !== 3'b000) begin
        failures++;
        $display("FAIL mid_first_hold k=%0d got srn=%b lvl=%b exp 0 000", k, bus.sys_reset_n, bus.btn_level);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.sys_reset_n !== 1'b0 || bus.reset_busy !== 1'b1 || bus.btn_level !== 3'b000) begin
      failures++;
      $display("FAIL mid_hold_reset got srn=%b busy=%b lvl=%b exp 0 1 000", bus.sys_reset_n, bus.reset_busy, bus.btn_level);
    end
    reset = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (bus.sys_reset_n !== (k >= 8) || bus.reset_busy !== (k < 8)) begin
        failures++;
        $display("FAIL mid_rehold k=%0d got srn=%b busy=%b exp srn=%b", k, bus.sys_reset_n, bus.reset_busy, k >= 8);
      end
      checks++;
      if (bus.btn_level[1] !== (k >= 6) || bus.btn_level[2] !== (k >= 6) || bus.btn_press[1] !== (k == 6)) begin
        failures++;
        $display("FAIL mid_redebounce k=%0d got lvl=%b prs=%b exp lvl12=%b prs1=%b", k,
                 bus.btn_level, bus.btn_press, k >= 6, k == 6);
      end
    end
    bus.btn_raw = 3'b111;
    for (int k = 0; k < 8; k++) step();
    checks++;
    if (bus.btn_level !== 3'b000 || bus.sys_reset_n !== 1'b1) begin
      failures++;
      $display("FAIL mid_final got lvl=%b srn=%b exp 000 1", bus.btn_level, bus.sys_reset_n);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    bus.btn_raw = 3'b111;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_button();
    test_midway_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
